// File: rtl/rgb_sbit_pkg.sv
// Shared definitions for the serial-bit to pixel-word assembler:
// status byte layout, FSM state encoding and legal pixel widths.
package rgb_sbit_pkg;

   localparam int unsigned BPP_GRB  = 24;
   localparam int unsigned BPP_GRBW = 32;

   // Bit offsets inside the status byte (top 8 bits of the output word)
   localparam int unsigned STAT_W       = 8;
   localparam int unsigned STAT_VALID   = 7;
   localparam int unsigned STAT_SRESET  = 6;
   localparam int unsigned STAT_PARTIAL = 5;
   localparam int unsigned STAT_RESYNC  = 4;

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_RESYNC = 1'b1
   } state_t;

   function automatic logic is_legal_bpp(input int unsigned bpp);
      return (bpp == BPP_GRB) || (bpp == BPP_GRBW);
   endfunction

   // Status byte of an emitted word; valid is always set, low nibble is zero
   function automatic logic [STAT_W-1:0] make_status(input logic sreset,
                                                     input logic partial,
                                                     input logic resync);
      logic [STAT_W-1:0] s;
      s               = '0;
      s[STAT_VALID]   = 1'b1;
      s[STAT_SRESET]  = sreset;
      s[STAT_PARTIAL] = partial;
      s[STAT_RESYNC]  = resync;
      return s;
   endfunction

endpackage

// File: rtl/rgb_strobe_edge.sv
// Registered rising-edge detector for the bit qualifier strobe.
module rgb_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   // Next history value is simply the current strobe level
   always_comb begin
      prev_d = strobe;
   end

   // Strobe history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= prev_d;
   end

   assign rise = strobe & ~prev_q;

endmodule

// File: rtl/rgbw_sbit2wrd.sv
// Assembles decoded serial LED bits (MSB first) into GRB/GRBW pixel words
// with a status byte, emits stream-reset words, and tracks FIFO overflow.
module rgbw_sbit2wrd
   import rgb_sbit_pkg::*;
#(
   parameter int unsigned BITS_PER_PIXEL = 24,
   parameter int unsigned PIX_CNT_W      = 12,
   localparam int unsigned WORD_W        = BITS_PER_PIXEL + 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_strobe,
   input  logic                 in_sbit_value,
   input  logic                 in_stream_reset,
   input  logic                 in_wr_fifo_full,
   output logic [WORD_W-1:0]    out_word,
   output logic                 out_strobe,
   output logic                 out_wr_fifo_overflow,
   output logic                 out_frame_done,
   output logic [PIX_CNT_W-1:0] out_pixel_count,
   output logic [PIX_CNT_W-1:0] out_drop_count
);

   localparam int unsigned IDX_W = $clog2(BITS_PER_PIXEL);
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(BITS_PER_PIXEL - 1);

   if (!is_legal_bpp(BITS_PER_PIXEL)) begin : g_bad_bpp
      $error("rgbw_sbit2wrd: BITS_PER_PIXEL must be 24 or 32");
   end

   logic                      rise;
   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [BITS_PER_PIXEL-1:0] data_q, data_d;
   logic [PIX_CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
   logic [WORD_W-1:0]         word_q, word_d;
   logic                      strobe_q, strobe_d;
   logic                      frame_done_q, frame_done_d;
   logic                      overflow_q, overflow_d;
   logic [PIX_CNT_W-1:0]      pixel_count_q, pixel_count_d;
   logic [PIX_CNT_W-1:0]      drop_q, drop_d;

   rgb_strobe_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (in_strobe),
      .rise   (rise)
   );

   // Next-state, word assembly, emit/drop decisions and counters
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      data_d        = data_q;
      pix_cnt_d     = pix_cnt_q;
      word_d        = word_q;
      strobe_d      = 1'b0;
      frame_done_d  = 1'b0;
      overflow_d    = overflow_q;
      pixel_count_d = pixel_count_q;
      drop_d        = drop_q;

      if (rise) begin
         unique case (state_q)
            ST_ACCUM: begin
               if (in_stream_reset) begin
                  // Stream reset wins over any data bit on the same edge
                  if (!in_wr_fifo_full) begin
                     word_d        = {make_status(1'b1, idx_q != IDX_FIRST, 1'b0), data_q};
                     strobe_d      = 1'b1;
                     frame_done_d  = 1'b1;
                     pixel_count_d = pix_cnt_q;
                     pix_cnt_d     = '0;
                  end else begin
                     overflow_d = 1'b1;
                     if (drop_q != '1) drop_d = drop_q + 1'b1;
                     state_d    = ST_RESYNC;
                  end
                  idx_d  = IDX_FIRST;
                  data_d = '0;
               end else begin
                  data_d[idx_q] = in_sbit_value;
                  if (idx_q == '0) begin
                     if (!in_wr_fifo_full) begin
                        word_d   = {make_status(1'b0, 1'b0, 1'b0), data_d};
                        strobe_d = 1'b1;
                        if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
                     end else begin
                        overflow_d = 1'b1;
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                        state_d    = ST_RESYNC;
                     end
                     idx_d  = IDX_FIRST;
                     data_d = '0;
                  end else begin
                     idx_d = idx_q - 1'b1;
                  end
               end
            end
            ST_RESYNC: begin
               if (in_stream_reset) begin
                  if (!in_wr_fifo_full) begin
                     word_d        = {make_status(1'b1, 1'b0, 1'b1), {BITS_PER_PIXEL{1'b0}}};
                     strobe_d      = 1'b1;
                     frame_done_d  = 1'b1;
                     pixel_count_d = pix_cnt_q;
                     pix_cnt_d     = '0;
                     state_d       = ST_ACCUM;
                  end else begin
                     overflow_d = 1'b1;
                     if (drop_q != '1) drop_d = drop_q + 1'b1;
                  end
                  idx_d  = IDX_FIRST;
                  data_d = '0;
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_ACCUM;
         idx_q         <= IDX_FIRST;
         data_q        <= '0;
         pix_cnt_q     <= '0;
         word_q        <= '0;
         strobe_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         overflow_q    <= 1'b0;
         pixel_count_q <= '0;
         drop_q        <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         data_q        <= data_d;
         pix_cnt_q     <= pix_cnt_d;
         word_q        <= word_d;
         strobe_q      <= strobe_d;
         frame_done_q  <= frame_done_d;
         overflow_q    <= overflow_d;
         pixel_count_q <= pixel_count_d;
         drop_q        <= drop_d;
      end
   end

   assign out_word             = word_q;
   assign out_strobe           = strobe_q;
   assign out_wr_fifo_overflow = overflow_q;
   assign out_frame_done       = frame_done_q;
   assign out_pixel_count      = pixel_count_q;
   assign out_drop_count       = drop_q;

endmodule

// File: tb/tb_rgbw_sbit2wrd.sv
// Directed bench for rgbw_sbit2wrd: GRB (24-bit) and GRBW (32-bit) instances
// share the same stimulus; each scenario checks hand-computed words.
module tb_rgbw_sbit2wrd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_strobe = 1'b0;
   logic        in_sbit_value = 1'b0;
   logic        in_stream_reset = 1'b0;
   logic        in_wr_fifo_full = 1'b0;

   logic [31:0] w24;
   logic        s24, ov24, fd24;
   logic [11:0] pc24, dc24;
   logic [39:0] w32;
   logic        s32, ov32, fd32;
   logic [11:0] pc32, dc32;

   int n_checks = 0;
   int n_pass   = 0;
   int str24    = 0;
   int str32    = 0;

   // Values captured one half-cycle after the clock edge that sampled a pulse
   logic [63:0] cw24, cs24, cfd24, cov24, cpc24, cdc24, cw32, cs32;

   always #5 clk = ~clk;

   rgbw_sbit2wrd #(.BITS_PER_PIXEL(24), .PIX_CNT_W(12)) dut24 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .in_strobe            (in_strobe),
      .in_sbit_value        (in_sbit_value),
      .in_stream_reset      (in_stream_reset),
      .in_wr_fifo_full      (in_wr_fifo_full),
      .out_word             (w24),
      .out_strobe           (s24),
      .out_wr_fifo_overflow (ov24),
      .out_frame_done       (fd24),
      .out_pixel_count      (pc24),
      .out_drop_count       (dc24)
   );

   rgbw_sbit2wrd #(.BITS_PER_PIXEL(32), .PIX_CNT_W(12)) dut32 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .in_strobe            (in_strobe),
      .in_sbit_value        (in_sbit_value),
      .in_stream_reset      (in_stream_reset),
      .in_wr_fifo_full      (in_wr_fifo_full),
      .out_word             (w32),
      .out_strobe           (s32),
      .out_wr_fifo_overflow (ov32),
      .out_frame_done       (fd32),
      .out_pixel_count      (pc32),
      .out_drop_count       (dc32)
   );

   // Count cycles with the write strobe high
   always @(posedge clk) begin
      if (s24) str24 <= str24 + 1;
      if (s32) str32 <= str32 + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One strobe pulse held for ncyc cycles; capture outputs after the first edge
   task automatic pulse(input logic sr, input logic v, input int ncyc);
      @(negedge clk);
      in_strobe       = 1'b1;
      in_sbit_value   = v;
      in_stream_reset = sr;
      @(negedge clk);
      cw24  = 64'(w24);
      cs24  = 64'(s24);
      cfd24 = 64'(fd24);
      cov24 = 64'(ov24);
      cpc24 = 64'(pc24);
      cdc24 = 64'(dc24);
      cw32  = 64'(w32);
      cs32  = 64'(s32);
      for (int i = 1; i < ncyc; i++) @(negedge clk);
      in_strobe       = 1'b0;
      in_sbit_value   = 1'b0;
      in_stream_reset = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] val, input int nbits);
      logic [31:0] tmp;
      tmp = val;
      for (int i = nbits - 1; i >= 0; i--) pulse(1'b0, tmp[i], 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int base;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_word",   64'(w24),  64'h0);
      check("rst_strobe", 64'(s24),  64'h0);
      check("rst_fd",     64'(fd24), 64'h0);
      check("rst_ovf",    64'(ov24), 64'h0);
      check("rst_pc",     64'(pc24), 64'h0);
      check("rst_dc",     64'(dc24), 64'h0);
      rst_n = 1'b1;

      // Full GRB pixel then stream reset
      base = str24;
      send_bits(32'hA5C33C, 24);
      check("pix_word",   cw24, 64'h80A5C33C);
      check("pix_strobe", cs24, 64'h1);
      @(negedge clk);
      check("pix_strobe_1cyc", 64'(s24), 64'h0);
      check("pix_nstrobes", 64'(str24 - base), 64'h1);
      pulse(1'b1, 1'b1, 1);
      check("sr_word", cw24,  64'hC0000000);
      check("sr_fd",   cfd24, 64'h1);
      check("sr_pc",   cpc24, 64'h1);

      // Five pending bits produce a partial stream-reset word
      send_bits(32'b10110, 5);
      pulse(1'b1, 1'b0, 1);
      check("part_word", cw24,  64'hE0B00000);
      check("part_pc",   cpc24, 64'h0);

      // Strobe held three cycles captures one bit
      @(negedge clk);
      base = str24;
      pulse(1'b0, 1'b1, 3);
      send_bits(32'b0000, 4);
      pulse(1'b1, 1'b0, 1);
      check("held_word", cw24, 64'hE0800000);
      @(negedge clk);
      check("held_nstrobes", 64'(str24 - base), 64'h1);

      // Stream reset coinciding with the last data bit dominates
      send_bits(32'h7FFFFF, 23);
      pulse(1'b1, 1'b1, 1);
      check("dom_word",   cw24,  64'hE0FFFFFE);
      check("dom_strobe", cs24,  64'h1);

      // FIFO full on the 24th bit drops the word and enters resync
      @(negedge clk);
      base = str24;
      send_bits(32'h123456, 23);
      in_wr_fifo_full = 1'b1;
      pulse(1'b0, 1'b1, 1);
      in_wr_fifo_full = 1'b0;
      check("ovf_strobe", cs24,  64'h0);
      check("ovf_flag",   cov24, 64'h1);
      check("ovf_drop",   cdc24, 64'h1);
      send_bits(32'hFFFFFF, 24);
      @(negedge clk);
      check("resync_nstrobes", 64'(str24 - base), 64'h0);
      pulse(1'b1, 1'b0, 1);
      check("resync_word", cw24,  64'hD0000000);
      check("resync_fd",   cfd24, 64'h1);
      check("resync_pc",   cpc24, 64'h0);
      check("ovf_sticky",  cov24, 64'h1);

      // Asynchronous reset mid-pixel
      send_bits(32'h3FF, 10);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_word", 64'(w24),  64'h0);
      check("mid_rst_ovf",  64'(ov24), 64'h0);
      check("mid_rst_dc",   64'(dc24), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send_bits(32'h123456, 24);
      check("post_rst_word",   cw24, 64'h80123456);
      check("post_rst_strobe", cs24, 64'h1);

      // GRBW instance: 32-bit pixel
      do_reset();
      base = str32;
      send_bits(32'h11223344, 32);
      check("w32_word",   cw32, 64'h8011223344);
      check("w32_strobe", cs32, 64'h1);
      @(negedge clk);
      check("w32_strobe_1cyc", 64'(s32), 64'h0);
      check("w32_nstrobes", 64'(str32 - base), 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rgbw_sbit2wrd.md
RGBW_SBIT2WRD -- requirements
Module: rgbw_sbit2wrd

Interface
REQ-001 SHALL have parameter BITS_PER_PIXEL, default 24, meaning data bits per pixel; legal values 24 (GRB) or 32 (GRBW).
REQ-002 SHALL have parameter PIX_CNT_W, default 12, meaning width of the pixel and drop counters.
REQ-003 SHALL have localparam WORD_W = BITS_PER_PIXEL+8, meaning output word width: status byte in the top 8 bits, data below.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, sole clock (96 MHz).
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port in_strobe, input, 1 bit, qualifier for the bit inputs; may stay high for 1 or more cycles.
REQ-008 SHALL have port in_sbit_value, input, 1 bit, decoded bit value.
REQ-009 SHALL have port in_stream_reset, input, 1 bit, 50 us latch/reset event.
REQ-010 SHALL have port in_wr_fifo_full, input, 1 bit, downstream FIFO cannot accept a word.
REQ-011 SHALL have port out_word, output, WORD_W bits, status byte plus pixel data.
REQ-012 SHALL have port out_strobe, output, 1 bit, 1-cycle write pulse.
REQ-013 SHALL have port out_wr_fifo_overflow, output, 1 bit, sticky overflow flag.
REQ-014 SHALL have port out_frame_done, output, 1 bit, 1-cycle pulse at each emitted stream-reset word.
REQ-015 SHALL have port out_pixel_count, output, PIX_CNT_W bits, count of full pixels in the last completed frame.
REQ-016 SHALL have port out_drop_count, output, PIX_CNT_W bits, saturating count of dropped words.

Function
REQ-017 SHALL act on the rising edge of in_strobe only; each further cycle of in_strobe high is ignored.
REQ-018 SHALL store data bits MSB first, starting at bit BITS_PER_PIXEL-1 and ending at bit 0.
REQ-019 SHALL use status bits as follows: bit WORD_W-1 = valid; WORD_W-2 = stream_reset; WORD_W-3 = partial; WORD_W-4 = resync; WORD_W-5..WORD_W-8 = 0.
REQ-020 SHALL implement two states: ACCUM and RESYNC; reset enters ACCUM.
REQ-021 SHALL emit a pixel word in ACCUM when a rising edge carries the last data bit and in_wr_fifo_full=0.
REQ-022 SHALL emit a stream-reset word in ACCUM when a rising edge has in_stream_reset=1 and in_wr_fifo_full=0; in_sbit_value is ignored for that edge.
REQ-023 SHALL fill the stream-reset word with the bits accumulated so far and zeros elsewhere, set stream_reset=1, and set partial=1 iff 1..BITS_PER_PIXEL-1 bits were pending.
REQ-024 SHALL assert out_strobe with valid=1 in the cycle after the clock edge that samples the qualifying rising edge, for exactly 1 cycle.
REQ-025 SHALL drop the word when a word is due and in_wr_fifo_full=1: out_wr_fifo_overflow set to 1 (sticky), out_drop_count+1 saturating at all-ones, enter RESYNC.
REQ-026 SHALL discard data bits in RESYNC and emit nothing for them.
REQ-027 SHALL, in RESYNC, on in_stream_reset with fifo not full, emit the stream-reset word with resync=1 and data=0, then return to ACCUM; with fifo full it stays in RESYNC and increments out_drop_count.
REQ-028 SHALL clear the bit index to the first bit after every emitted or dropped word.
REQ-029 SHALL count only emitted full-pixel words into the frame pixel count.
REQ-030 SHALL, at each emitted stream-reset word, copy the pixel count to out_pixel_count, pulse out_frame_done together with out_strobe, and clear the running count.
REQ-031 SHALL saturate the running pixel count at all-ones.
REQ-032 SHALL treat in_stream_reset as dominant when it coincides with the last data bit.

Reset
REQ-033 SHALL, while rst_n=0, immediately set out_word=0, out_strobe=0, out_frame_done=0, out_wr_fifo_overflow=0, out_pixel_count=0, out_drop_count=0, state=ACCUM, bit index=first, strobe-edge history=0.
REQ-034 SHALL discard a partly received pixel when reset occurs mid-pixel.
REQ-035 SHALL release reset on the first clk edge after rst_n rises.

Structure
REQ-036 SHALL keep status bit offsets, state encoding and legal BITS_PER_PIXEL values in shared package rgb_sbit_pkg.
REQ-037 SHALL instantiate one sub-module, rgb_strobe_edge: a registered rising-edge detector on in_strobe.

Verification
REQ-038 SHALL verify: BITS_PER_PIXEL=24, bits 0xA5C33C MSB-first, then stream reset -> out_word 0x80A5C33C, then 0xC0000000, out_frame_done=1, out_pixel_count=1.
REQ-039 SHALL verify: BITS_PER_PIXEL=32, 0x11223344 -> 40-bit out_word 0x8011223344, strobe 1 cycle.
REQ-040 SHALL verify: 5 bits 10110, then stream reset -> out_word 0xE0B00000 (partial=1).
REQ-041 SHALL verify: fifo full at the 24th bit -> no strobe, overflow=1, drop=1; next pixel ignored; stream reset with fifo free -> out_word 0xD0000000.
REQ-042 SHALL verify: in_strobe held 3 cycles -> single bit captured; rst_n low mid-pixel -> all outputs 0, next pixel assembles from bit 23.
